// File: rtl/crash_detector.sv
// rtl/crash_detector.sv - player/enemy collision judge with hit filter, hold, invulnerability and lives
//
// Compares the player box against one enemy box each cycle. A hit needs
// CONFIRM_CYC consecutive cycles of registered overlap. crash is then held
// for HOLD_CYC cycles, overlap is ignored for INVULN_CYC cycles, and the
// judge re-arms. Each hit costs one life. The last life latches game_over.
//
// Ports:
//   clk        in   1   system clock
//   rst        in   1   asynchronous, active-high reset
//   player_x   in  12   player box top-left x
//   player_y   in  12   player box top-left y
//   enemy_x    in  12   enemy box top-left x
//   enemy_y    in  12   enemy box top-left y
//   crash      out  1   collision active (hold window or game over)
//   lives      out  4   remaining lives
//   game_over  out  1   lives exhausted, sticky until rst

module crash_detector #(
  parameter int PLANE_W     = 60,
  parameter int PLANE_H     = 40,
  parameter int ENEMY_W     = 50,
  parameter int ENEMY_H     = 40,
  parameter int CONFIRM_CYC = 4,
  parameter int HOLD_CYC    = 1000000,
  parameter int INVULN_CYC  = 50000000,
  parameter int LIVES       = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] player_x,
  input  logic [11:0] player_y,
  input  logic [11:0] enemy_x,
  input  logic [11:0] enemy_y,
  output logic        crash,
  output logic [3:0]  lives,
  output logic        game_over
);

  localparam int MAX_A = (HOLD_CYC > INVULN_CYC) ? HOLD_CYC : INVULN_CYC;
  localparam int MAX_C = (MAX_A > CONFIRM_CYC) ? MAX_A : CONFIRM_CYC;
  localparam int CW    = $clog2(MAX_C + 1);

  typedef enum logic [1:0] {ARMED, HIT, INVULN, OVER} state_t;

  state_t        state, state_n;
  logic [CW-1:0] run_cnt, run_n;
  logic [CW-1:0] tmr, tmr_n;
  logic [3:0]    lives_n;
  logic [3:0]    lives_dec;
  logic          ov, ov_q;

  // Extend to 13 bits so box edges near 4095 cannot wrap into a false overlap.
  logic [12:0] px, py, ex, ey;
  assign px = {1'b0, player_x};
  assign py = {1'b0, player_y};
  assign ex = {1'b0, enemy_x};
  assign ey = {1'b0, enemy_y};

  // Strict compares: boxes touching edge-to-edge do not overlap.
  assign ov = (px < ex + 13'(ENEMY_W)) && (ex < px + 13'(PLANE_W)) &&
              (py < ey + 13'(ENEMY_H)) && (ey < py + 13'(PLANE_H));

  // Saturating decrement; lives can never wrap below zero.
  assign lives_dec = (lives == 4'd0) ? 4'd0 : lives - 4'd1;

  always_comb begin
    state_n = state;
    run_n   = run_cnt;
    tmr_n   = tmr;
    lives_n = lives;
    case (state)
      ARMED: begin
        if (ov_q) begin
          if (run_cnt == CW'(CONFIRM_CYC - 1)) begin
            run_n   = '0;
            tmr_n   = '0;
            lives_n = lives_dec;
            state_n = (lives_dec == 4'd0) ? OVER : HIT;
          end else begin
            run_n = run_cnt + CW'(1);
          end
        end else begin
          run_n = '0;
        end
      end
      HIT: begin
        if (tmr == CW'(HOLD_CYC - 1)) begin
          state_n = INVULN;
          tmr_n   = '0;
        end else begin
          tmr_n = tmr + CW'(1);
        end
      end
      INVULN: begin
        // Overlap still present on exit must re-qualify from zero.
        if (tmr == CW'(INVULN_CYC - 1)) begin
          state_n = ARMED;
          tmr_n   = '0;
          run_n   = '0;
        end else begin
          tmr_n = tmr + CW'(1);
        end
      end
      OVER: begin
        lives_n = 4'd0;
      end
      default: begin
        state_n = ARMED;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ARMED;
      run_cnt   <= '0;
      tmr       <= '0;
      ov_q      <= 1'b0;
      lives     <= 4'(LIVES);
      crash     <= 1'b0;
      game_over <= 1'b0;
    end else begin
      state     <= state_n;
      run_cnt   <= run_n;
      tmr       <= tmr_n;
      ov_q      <= ov;
      lives     <= lives_n;
      // Outputs registered from next state so they line up with the state register.
      crash     <= (state_n == HIT) || (state_n == OVER);
      game_over <= (state_n == OVER);
    end
  end

endmodule
